// File: rtl/fifo_unpacker.sv
// Splits each word read from a show-ahead FIFO into DATA_WIDTH/OUT_WIDTH slices
// and emits them one per accepted handshake on a valid/ready stream.
module fifo_unpacker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned LSB_FIRST  = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rpull,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic [15:0]           word_cnt
);
    localparam int unsigned N     = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic                    hs;

    function automatic logic [OUT_WIDTH-1:0] slice_of(
        input logic [DATA_WIDTH-1:0] w,
        input logic [IDX_W-1:0]      k
    );
        int unsigned pos;
        pos = 32'(k);
        if (LSB_FIRST == 0) pos = N - 1 - pos;
        return w[pos*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    always_comb begin
        hs    = out_valid_q && out_ready;
        // Gated by rrst_n so the FIFO is never popped while the unpacker is held in reset.
        rpull = rrst_n && !rempty && !flush &&
                (state_q == IDLE || (hs && idx_q == LAST_IDX));

        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;

        if (rpull) begin
            state_d     = SEND;
            idx_d       = '0;
            word_d      = rdata;
            out_data_d  = slice_of(rdata, '0);
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            word_cnt_d  = word_cnt_q + 16'd1;
        end else if (flush) begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (state_q == SEND && hs) begin
            if (idx_q != LAST_IDX) begin
                idx_d      = idx_q + 1'b1;
                out_data_d = slice_of(word_q, idx_q + 1'b1);
                out_last_d = ((idx_q + 1'b1) == LAST_IDX);
            end else begin
                state_d     = IDLE;
                idx_d       = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Randomized bench for fifo_unpacker: a queue-based FIFO and slice scoreboard
// predict every output; a second instance covers MSB-first slice order.
module tb_fifo_unpacker;
    localparam int N = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rempty, flush, out_ready, rpull, out_valid, out_last;
    logic [31:0] rdata;
    logic [7:0]  out_data;
    logic [15:0] word_cnt;

    logic        b_rempty, b_flush, b_out_ready, b_rpull, b_out_valid, b_out_last;
    logic [31:0] b_rdata;
    logic [7:0]  b_out_data;
    logic [15:0] b_word_cnt;

    fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1)) dut (
        .rclk(clk), .rrst_n(rst_n), .rempty(rempty), .rdata(rdata), .rpull(rpull),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .word_cnt(word_cnt)
    );

    fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(0)) u_msb (
        .rclk(clk), .rrst_n(rst_n), .rempty(b_rempty), .rdata(b_rdata), .rpull(b_rpull),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .word_cnt(b_word_cnt)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, source of words to feed it, and the
    // slices still owed to the sink for the word currently held.
    logic [31:0] src_q[$];
    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] m_cnt;
    int          cyc;
    int          dut_pulls[$];
    int unsigned delivered;

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input logic f, input logic rdy, input int unsigned pct);
        logic        exp_pull, hs;
        logic [31:0] w;
        if (src_q.size() > 0 && $urandom_range(99) < pct) fifo_q.push_back(src_q.pop_front());
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("word_cnt", 32'(word_cnt), 32'(m_cnt));
        if (out_valid && exp_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        end
        flush     = f;
        out_ready = rdy;
        rempty    = (fifo_q.size() == 0);
        rdata     = rempty ? $urandom : fifo_q[0];
        #1;
        exp_pull = !rempty && !f &&
                   (exp_q.size() == 0 || (exp_q.size() == 1 && out_valid && rdy));
        check("rpull", 32'(rpull), 32'(exp_pull));
        hs = out_valid && rdy;
        if (rpull) dut_pulls.push_back(cyc);
        if (hs) delivered++;
        @(posedge clk);
        if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
        if (f) exp_q.delete();
        if (exp_pull) begin
            w = fifo_q.pop_front();
            for (int k = 0; k < N; k++) exp_q.push_back(8'(w >> (8 * k)));
            m_cnt = m_cnt + 16'd1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned n;
        n = 0;
        while ((src_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            tick(1'b0, 1'b1, 100);
            n++;
        end
        check("drain_timeout", 32'(n < bound), 32'd1);
    endtask

    initial begin
        logic [15:0] saved;
        logic [31:0] bw;
        int unsigned n;

        rst_n = 1'b0; rempty = 1'b0; rdata = 32'h1234_5678; flush = 1'b0; out_ready = 1'b1;
        b_rempty = 1'b1; b_rdata = '0; b_flush = 1'b0; b_out_ready = 1'b1;
        m_cnt = '0; cyc = 0; delivered = 0;
        #1;
        check("rst_rpull", 32'(rpull), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_rpull_hold", 32'(rpull), 32'd0);
        check("rst_valid_hold", 32'(out_valid), 32'd0);
        rempty = 1'b1;
        rst_n  = 1'b1;

        // Single word
        fifo_q.push_back(32'h4433_2211);
        repeat (8) tick(1'b0, 1'b1, 100);
        check("single_cnt", 32'(word_cnt), 32'd1);

        // Back-to-back stream: no bubbles, one pop every N cycles
        dut_pulls.delete();
        delivered = 0;
        for (int i = 0; i < 20; i++) fifo_q.push_back(32'(i + 2));
        repeat (84) tick(1'b0, 1'b1, 100);
        check("stream_slices", delivered, 32'd80);
        check("stream_pulls", 32'(dut_pulls.size()), 32'd20);
        for (int i = 1; i < dut_pulls.size(); i++)
            check("stream_gap", 32'(dut_pulls[i] - dut_pulls[i-1]), 32'(N));
        check("stream_cnt", 32'(word_cnt), 32'd21);

        // Random backpressure and intermittent FIFO fill
        for (int i = 0; i < 16; i++) src_q.push_back($urandom);
        n = 0;
        while ((src_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
            tick(1'b0, 1'($urandom_range(1)), 50);
            n++;
        end
        check("bp_timeout", 32'(n < 2000), 32'd1);

        // Flush while slice 1 (0xBB) is handshaken
        fifo_q.push_back(32'hDDCC_BBAA);
        fifo_q.push_back(32'h1122_3344);
        n = 0;
        while (exp_q.size() != 3 && n < 20) begin tick(1'b0, 1'b1, 100); n++; end
        check("flush_reach", 32'(out_data), 32'h0000_00BB);
        saved = word_cnt;
        tick(1'b1, 1'b1, 100);
        check("flush_cnt", 32'(word_cnt), 32'(saved));
        check("flush_idle", 32'(out_valid), 32'd0);
        tick(1'b0, 1'b1, 100);
        check("flush_next", 32'(out_data), 32'h0000_0044);
        drain(50);

        // Reset mid-word at idx=2
        fifo_q.push_back(32'hAABB_CCDD);
        fifo_q.push_back(32'h5566_7788);
        n = 0;
        while (exp_q.size() != 2 && n < 20) begin tick(1'b0, 1'b1, 100); n++; end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cnt", 32'(word_cnt), 32'd0);
        check("midrst_rpull", 32'(rpull), 32'd0);
        exp_q.delete();
        m_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b1, 100);
        check("midrst_first", 32'(out_data), 32'h0000_0088);
        drain(50);

        // Counter wrap: preload all-ones then pop one word
        force dut.word_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_cnt_q;
        m_cnt = 16'hFFFF;
        fifo_q.push_back(32'hCAFE_F00D);
        repeat (6) tick(1'b0, 1'b1, 100);
        check("wrap_cnt", 32'(word_cnt), 32'd0);

        // Mixed random flush, backpressure and fill
        for (int i = 0; i < 40; i++) src_q.push_back($urandom);
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(99) < 5), 1'($urandom_range(99) < 70), 40);
        drain(400);

        // MSB-first instance
        bw = 32'h4433_2211;
        b_rdata  = bw;
        b_rempty = 1'b0;
        #1;
        check("msb_rpull", 32'(b_rpull), 32'd1);
        @(posedge clk);
        #1 b_rempty = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check("msb_valid", 32'(b_out_valid), 32'd1);
            check("msb_data", 32'(b_out_data), 32'(8'(bw >> (8 * (N - 1 - k)))));
            check("msb_last", 32'(b_out_last), 32'(k == N - 1));
        end
        @(negedge clk);
        check("msb_idle", 32'(b_out_valid), 32'd0);
        check("msb_cnt", 32'(b_word_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_unpacker.md
FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read-side word.
REQ-002 Parameter OUT_WIDTH, default 8, width of emitted slice; DATA_WIDTH SHALL be an integer multiple (N = DATA_WIDTH/OUT_WIDTH, N >= 2).
REQ-003 Parameter LSB_FIRST, default 1, slice order (1: bits [OUT_WIDTH-1:0] first; 0: MSB slice first).
REQ-004 rclk  input  1  single clock, rising-edge; same clock as the FIFO read domain.
REQ-005 rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rempty  input  1  FIFO read side empty; rdata valid whenever rempty=0 (show-ahead).
REQ-007 rdata  input  DATA_WIDTH  FIFO head word.
REQ-008 rpull  output  1  pop FIFO head at this rising edge.
REQ-009 flush  input  1  synchronous discard of the word in progress.
REQ-010 out_valid  output  1  out_data holds a valid slice.
REQ-011 out_ready  input  1  sink accepts slice when out_valid=1 at the same edge.
REQ-012 out_data  output  OUT_WIDTH  current slice.
REQ-013 out_last  output  1  current slice is the final slice of its word.
REQ-014 word_cnt  output  16  count of words popped, wraps 0xFFFF -> 0x0000.

Function
REQ-015 Two states SHALL exist: IDLE (no word held) and SEND (word register holds a word, slice index idx in 0..N-1).
REQ-016 rpull SHALL be combinational: rpull = !rempty && !flush && (state==IDLE || (out_valid && out_ready && idx==N-1)).
REQ-017 rpull SHALL never be 1 while rempty=1.
REQ-018 On any edge with rpull=1, rdata SHALL be loaded into the word register, idx cleared to 0, state set to SEND, word_cnt incremented by 1.
REQ-019 In SEND, out_valid SHALL be 1 and out_data SHALL be slice idx (slice k = bits [k*OUT_WIDTH +: OUT_WIDTH] if LSB_FIRST=1, else slice N-1-k).
REQ-020 In IDLE, out_valid SHALL be 0; out_data SHALL hold its last value (don't-care for checking).
REQ-021 out_last SHALL equal (state==SEND && idx==N-1).
REQ-022 Handshake at an edge with out_valid && out_ready: if idx<N-1, idx increments; if idx==N-1 and rpull=1, next word loads with no bubble; if idx==N-1 and rpull=0, state goes IDLE.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and idx SHALL remain stable.
REQ-024 Latency: rempty falling at edge T with state IDLE -> rpull high in cycle after T -> out_valid high one edge later (first slice available one cycle after the pop).
REQ-025 Sustained throughput with out_ready=1 and FIFO non-empty: exactly one slice per cycle, one rpull every N cycles.
REQ-026 flush=1 at an edge SHALL force state IDLE and suppress rpull that cycle, regardless of out_ready; a slice handshaken in the same cycle counts as delivered, remaining slices are dropped; word_cnt is unchanged.
REQ-027 rempty rising while in SEND SHALL not affect the held word; completion then returns to IDLE.

Reset
REQ-028 rrst_n=0 SHALL immediately force state IDLE, idx=0, out_valid=0, out_last=0, out_data=0, word_cnt=0, and word register 0.
REQ-029 While rrst_n=0, rpull SHALL be 0 regardless of rempty.
REQ-030 Reset asserted mid-word SHALL discard that word; after release the block resumes from IDLE with the next FIFO head.

Verification
REQ-031 Single word: FIFO holds 0x44332211, out_ready=1 -> one rpull, out_data 0x11,0x22,0x33,0x44 on consecutive cycles, out_last only with 0x44, word_cnt=1.
REQ-032 Stream: 20 words i+2 (i=0..19) pushed, out_ready=1 -> 80 slices in order with no bubbles between words, 20 rpull pulses each spaced 4 cycles, word_cnt=20.
REQ-033 Backpressure: out_ready toggled pseudo-randomly over 16 words -> no slice lost or duplicated, out_data stable whenever out_valid && !out_ready, rpull never while rempty=1.
REQ-034 Flush: flush=1 when idx=1 of 0xDDCCBBAA -> only 0xAA,0xBB delivered (if 0xBB handshaken that cycle), next slice is 0x.. slice 0 of the following word, word_cnt unchanged by flush.
REQ-035 Reset mid-word: rrst_n low at idx=2 -> out_valid=0 and word_cnt=0 same cycle; after release with FIFO non-empty, first emitted slice is slice 0 of the next FIFO head.
REQ-036 LSB_FIRST=0, word 0x44332211 -> slices 0x44,0x33,0x22,0x11; word_cnt wrap checked by preloading 0xFFFF -> 0x0000 after next pop.
